// File: rtl/max_pkg.sv
// Shared constants and helpers for the max_bus_seq phi0 bus sequencer.
package max_pkg;

  localparam int RD_SLOT_OFS     = 4;
  localparam int SAMPLE_SLOT_OFS = 2;

  typedef logic [1:0] ba_cnt_t;

  localparam ba_cnt_t BA_CNT_SAT = 2'd3;

  // The CPU may finish up to three writes after ba drops; a read stalls at once.
  function automatic logic calc_stall(input logic ba, input logic cpu_we, input ba_cnt_t cnt);
    return !ba && (!cpu_we || (cnt == BA_CNT_SAT));
  endfunction

  function automatic ba_cnt_t ba_cnt_next(input logic ba, input ba_cnt_t cnt);
    ba_cnt_t nxt;
    if (ba) begin
      nxt = 2'd0;
    end else if (cnt == BA_CNT_SAT) begin
      nxt = BA_CNT_SAT;
    end else begin
      nxt = cnt + 2'd1;
    end
    return nxt;
  endfunction

  function automatic logic aec_from(input logic ba, input ba_cnt_t cnt);
    return !((cnt == BA_CNT_SAT) && !ba);
  endfunction

endpackage

// File: rtl/max_ba_tracker.sv
// Counts phi0 cycles spent with ba low and derives the CPU address-enable (aec).
module max_ba_tracker
  import max_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       ba,
  output logic [1:0] ba_cnt,
  output logic       aec
);

  ba_cnt_t cnt_q, cnt_d;
  logic    aec_q, aec_d;

  always_comb begin
    if (tick) begin
      cnt_d = ba_cnt_next(ba, cnt_q);
      aec_d = aec_from(ba, cnt_d);
    end else begin
      cnt_d = cnt_q;
      aec_d = aec_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 2'd0;
      aec_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      aec_q <= aec_d;
    end
  end

  assign ba_cnt = cnt_q;
  assign aec    = aec_q;

endmodule

// File: rtl/max_bus_seq.sv
// phi0 slot sequencer with VIC bus stealing; MAX_BUS_SEQ_STEAL_CNT_EN enables the
// saturating stolen-cycle counter on steal_cnt (tied to zero otherwise).
module max_bus_seq
  import max_pkg::*;
#(
  parameter int CLK_PER_PHI = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ba,
  input  logic        cpu_we,
  output logic        phi0,
  output logic        enable_cpu,
  output logic        enable_cia,
  output logic        enable_pixel,
  output logic        pulse_rd,
  output logic        aec,
  output logic        vic_grant,
  output logic [15:0] steal_cnt
);

  localparam int SW = $clog2(CLK_PER_PHI);
  localparam int PW = $clog2(CLK_PER_PHI / 8);
  localparam logic [SW-1:0] LAST_SLOT   = SW'(CLK_PER_PHI - 1);
  localparam logic [SW-1:0] SAMPLE_SLOT = SW'(CLK_PER_PHI - SAMPLE_SLOT_OFS);
  localparam logic [SW-1:0] RD_SLOT     = SW'(CLK_PER_PHI - RD_SLOT_OFS);

  logic [SW-1:0] slot_q, slot_d;
  logic phi0_q, phi0_d;
  logic cpu_q, cpu_d;
  logic cia_q, cia_d;
  logic pix_q, pix_d;
  logic rd_q, rd_d;
  logic vg_q, vg_d;
  logic tick_s, stall_s, aec_s, aec_nxt_s;
  ba_cnt_t ba_cnt_s;

  // ba and cpu_we are acted on at the edge that leaves the sample slot.
  assign tick_s  = (slot_q == SAMPLE_SLOT);
  assign stall_s = calc_stall(ba, cpu_we, ba_cnt_s);

  max_ba_tracker u_trk (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick_s),
    .ba      (ba),
    .ba_cnt  (ba_cnt_s),
    .aec     (aec_s)
  );

  // Every strobe is decoded from the next slot so it lines up with its own slot.
  always_comb begin
    if (slot_q == LAST_SLOT) begin
      slot_d = {SW{1'b0}};
    end else begin
      slot_d = slot_q + {{(SW-1){1'b0}}, 1'b1};
    end
    if (tick_s) begin
      aec_nxt_s = aec_from(ba, ba_cnt_next(ba, ba_cnt_s));
    end else begin
      aec_nxt_s = aec_s;
    end
    phi0_d = slot_d[SW-1];
    cia_d  = (slot_d == LAST_SLOT);
    cpu_d  = cia_d && !stall_s;
    pix_d  = &slot_d[PW-1:0];
    rd_d   = (slot_d == RD_SLOT) && phi0_d && !cpu_we && !stall_s;
    vg_d   = !phi0_d || !aec_nxt_s;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q <= {SW{1'b0}};
      phi0_q <= 1'b0;
      cpu_q  <= 1'b0;
      cia_q  <= 1'b0;
      pix_q  <= 1'b0;
      rd_q   <= 1'b0;
      vg_q   <= 1'b1;
    end else begin
      slot_q <= slot_d;
      phi0_q <= phi0_d;
      cpu_q  <= cpu_d;
      cia_q  <= cia_d;
      pix_q  <= pix_d;
      rd_q   <= rd_d;
      vg_q   <= vg_d;
    end
  end

`ifdef MAX_BUS_SEQ_STEAL_CNT_EN
  logic [15:0] steal_q, steal_d;

  always_comb begin
    if (tick_s && stall_s && (steal_q != 16'hFFFF)) begin
      steal_d = steal_q + 16'd1;
    end else begin
      steal_d = steal_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      steal_q <= 16'h0000;
    end else begin
      steal_q <= steal_d;
    end
  end

  assign steal_cnt = steal_q;
`else
  assign steal_cnt = 16'h0000;
`endif

  assign phi0         = phi0_q;
  assign enable_cpu   = cpu_q;
  assign enable_cia   = cia_q;
  assign enable_pixel = pix_q;
  assign pulse_rd     = rd_q;
  assign aec          = aec_s;
  assign vic_grant    = vg_q;

endmodule

// File: tb/tb_max_bus_seq.sv
// Randomized self-checking bench for max_bus_seq against a per-phi0-cycle reference model.
module tb_max_bus_seq;

  localparam int N = 32;
  localparam int P = N / 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ba;
  logic        cpu_we;
  logic        phi0, enable_cpu, enable_cia, enable_pixel, pulse_rd, aec, vic_grant;
  logic [15:0] steal_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  int cnt_m;
  bit aec_m;
  int steal_m;

  int c_cpu, c_cia, c_pix, c_rd, c_phi_hi, c_rise, c_vgl;
  bit phi_prev;

  max_bus_seq #(.CLK_PER_PHI(N)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ba           (ba),
    .cpu_we       (cpu_we),
    .phi0         (phi0),
    .enable_cpu   (enable_cpu),
    .enable_cia   (enable_cia),
    .enable_pixel (enable_pixel),
    .pulse_rd     (pulse_rd),
    .aec          (aec),
    .vic_grant    (vic_grant),
    .steal_cnt    (steal_cnt)
  );

  always #5 clk = ~clk;

  task automatic clear_tallies();
    c_cpu = 0; c_cia = 0; c_pix = 0; c_rd = 0; c_phi_hi = 0; c_rise = 0; c_vgl = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    logic [6:0] got;
    got = {phi0, enable_cpu, enable_cia, enable_pixel, pulse_rd, aec, vic_grant};
    n_cmp++;
    if (got !== 7'b0000011) begin
      n_bad++;
      $display("FAIL %s outputs: got %b expected 0000011", tag, got);
    end
    n_cmp++;
    if (steal_cnt !== 16'h0000) begin
      n_bad++;
      $display("FAIL %s steal_cnt: got %0d expected 0", tag, steal_cnt);
    end
  endtask

  // Leaves the bench at a negedge with the DUT in slot 0.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    ba = 1'b1;
    cpu_we = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cnt_m = 0; aec_m = 1'b1; steal_m = 0; phi_prev = 1'b0;
  endtask

  // One phi0 cycle: model the cycle's outcome, then check every clk of it.
  task automatic run_cycle(input bit ba_v, input bit we_v);
    bit stall, aec_n, ph, a;
    int cnt_n, steal_n;
    logic [6:0] exp_v, got_v;
    logic [15:0] exp_s;
    ba = ba_v;
    cpu_we = we_v;
    stall = !ba_v && (!we_v || cnt_m == 3);
    cnt_n = ba_v ? 0 : ((cnt_m < 3) ? cnt_m + 1 : 3);
    aec_n = !(cnt_n == 3 && !ba_v);
`ifdef MAX_BUS_SEQ_STEAL_CNT_EN
    steal_n = (stall && steal_m < 65535) ? steal_m + 1 : steal_m;
`else
    steal_n = 0;
`endif
    for (int s = 0; s < N; s++) begin
      ph = (s >= N / 2);
      a = (s == N - 1) ? aec_n : aec_m;
      exp_v = {ph, (s == N - 1) && !stall, (s == N - 1), (s % P) == P - 1,
               (s == N - 4) && !we_v && !stall, a, !ph || !a};
      got_v = {phi0, enable_cpu, enable_cia, enable_pixel, pulse_rd, aec, vic_grant};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL outputs slot %0d ba=%0b we=%0b: got %b expected %b", s, ba_v, we_v, got_v, exp_v);
      end
      exp_s = (s == N - 1) ? steal_n[15:0] : steal_m[15:0];
      n_cmp++;
      if (steal_cnt !== exp_s) begin
        n_bad++;
        $display("FAIL steal_cnt slot %0d: got %0d expected %0d", s, steal_cnt, exp_s);
      end
      if (enable_cpu) c_cpu++;
      if (enable_cia) c_cia++;
      if (enable_pixel) c_pix++;
      if (pulse_rd) c_rd++;
      if (phi0) c_phi_hi++;
      if (phi0 && !phi_prev) c_rise++;
      if (!vic_grant) c_vgl++;
      phi_prev = phi0;
      @(posedge clk);
      @(negedge clk);
    end
    cnt_m = cnt_n;
    aec_m = aec_n;
    steal_m = steal_n;
  endtask

  task automatic expect_int(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Counts edges after release until the strobe is consumed; bounded by 2N.
  task automatic measure_first_cpu(input string tag);
    int first;
    first = 0;
    for (int i = 1; i <= 2 * N; i++) begin
      @(posedge clk);
      #1;
      if (enable_cpu && first == 0) first = i + 1;
    end
    expect_int(tag, first, N);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    ba = 1'b1;
    cpu_we = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    measure_first_cpu("first_cpu_after_reset");
  endtask

  task automatic test_free_run();
    int n_rd;
    bit we;
    do_reset();
    clear_tallies();
    n_rd = 0;
    for (int c = 0; c < 1024 / N; c++) begin
      we = 1'($urandom_range(0, 1));
      if (!we) n_rd++;
      run_cycle(1'b1, we);
    end
    expect_int("free_run enable_cpu", c_cpu, 32);
    expect_int("free_run enable_cia", c_cia, 32);
    expect_int("free_run enable_pixel", c_pix, 256);
    expect_int("free_run phi0 high clks", c_phi_hi, 512);
    expect_int("free_run phi0 periods", c_rise, 32);
    expect_int("free_run pulse_rd", c_rd, n_rd);
  endtask

  task automatic test_read_steal();
    int k;
    run_cycle(1'b1, 1'b0);
    k = $urandom_range(3, 8);
    clear_tallies();
    for (int c = 0; c < k; c++) run_cycle(1'b0, 1'b0);
    expect_int("read_steal enable_cpu", c_cpu, 0);
    expect_int("read_steal pulse_rd", c_rd, 0);
    run_cycle(1'b1, 1'b0);
  endtask

  task automatic test_write_steal();
    clear_tallies();
    for (int c = 0; c < 3; c++) run_cycle(1'b0, 1'b1);
    expect_int("write_steal cpu pulses", c_cpu, 3);
    clear_tallies();
    for (int c = 0; c < 3; c++) run_cycle(1'b0, 1'b1);
    expect_int("write_steal halted cpu", c_cpu, 0);
    expect_int("write_steal vic_grant low clks", c_vgl, 0);
    expect_int("write_steal aec", int'(aec), 0);
    clear_tallies();
    run_cycle(1'b1, 1'b1);
    expect_int("write_resume cpu", c_cpu, 1);
  endtask

  task automatic test_long_steal();
    do_reset();
    run_cycle(1'b1, 1'b0);
    for (int c = 0; c < 40; c++) run_cycle(1'b0, 1'b0);
    clear_tallies();
    run_cycle(1'b1, 1'b0);
    expect_int("long_steal resume cpu", c_cpu, 1);
    expect_int("long_steal aec", int'(aec), 1);
    expect_int("long_steal ba_cnt", int'(dut.u_trk.ba_cnt), 0);
`ifdef MAX_BUS_SEQ_STEAL_CNT_EN
    expect_int("long_steal steal_cnt", int'(steal_cnt), 40);
`else
    expect_int("long_steal steal_cnt", int'(steal_cnt), 0);
`endif
  endtask

  task automatic test_random();
    bit b;
    b = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if ($urandom_range(0, 3) == 0) b = !b;
      run_cycle(b, 1'($urandom_range(0, 1)));
    end
    run_cycle(1'b1, 1'b0);
  endtask

  task automatic test_reset_midcycle();
    for (int c = 0; c < 4; c++) run_cycle(1'b0, 1'b0);
    repeat (17) @(posedge clk);
    #2;
    expect_int("pre_reset phi0", int'(phi0), 1);
    expect_int("pre_reset aec", int'(aec), 0);
    reset_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    @(posedge clk);
    #1;
    check_reset_vals("reset_next_clk");
    ba = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    measure_first_cpu("first_cpu_after_midcycle_reset");
  endtask

  task automatic test_steal_sat();
    do_reset();
    run_cycle(1'b1, 1'b0);
`ifdef MAX_BUS_SEQ_STEAL_CNT_EN
    force dut.steal_q = 16'hFFFD;
    #1;
    release dut.steal_q;
    steal_m = 65533;
    for (int c = 0; c < 5; c++) run_cycle(1'b0, 1'b0);
    expect_int("steal_sat", int'(steal_cnt), 65535);
`else
    for (int c = 0; c < 5; c++) run_cycle(1'b0, 1'b0);
    expect_int("steal_tied", int'(steal_cnt), 0);
`endif
    run_cycle(1'b1, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    ba = 1'b1;
    cpu_we = 1'b0;
    test_reset();
    test_free_run();
    test_read_steal();
    test_write_steal();
    test_long_steal();
    test_random();
    test_reset_midcycle();
    test_steal_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/max_bus_seq.md
MAX_BUS_SEQ -- requirements
Module: max_bus_seq

Interface
REQ-001 SHALL have parameter CLK_PER_PHI, default 32, meaning clk cycles per phi0 period; legal values are powers of two, 16..64.
REQ-002 SHALL have port clk, input, 1 bit: system clock (32 MHz), sole clock.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port ba, input, 1 bit: VIC bus-available; low means the VIC requests the bus.
REQ-005 SHALL have port cpu_we, input, 1 bit: the current CPU cycle is a write.
REQ-006 SHALL have port phi0, output, 1 bit: 0 = VIC half-cycle, 1 = CPU half-cycle.
REQ-007 SHALL have port enable_cpu, output, 1 bit: one-clk CPU advance strobe.
REQ-008 SHALL have port enable_cia, output, 1 bit: one-clk CIA advance strobe.
REQ-009 SHALL have port enable_pixel, output, 1 bit: pixel strobe at 8x the phi0 rate.
REQ-010 SHALL have port pulse_rd, output, 1 bit: one-clk read-strobe for register side effects.
REQ-011 SHALL have port aec, output, 1 bit: CPU owns the address bus.
REQ-012 SHALL have port vic_grant, output, 1 bit: shared RAM/colour-RAM address mux selects the VIC.
REQ-013 SHALL have port steal_cnt, output, 16 bits: count of stalled CPU cycles.

Function
REQ-014 SHALL hold a slot counter, log2(CLK_PER_PHI) bits, incrementing every clk and wrapping from CLK_PER_PHI-1 to 0.
REQ-015 SHALL drive phi0 = MSB of the slot counter, registered.
REQ-016 SHALL pulse enable_pixel for one clk whenever slot mod (CLK_PER_PHI/8) == CLK_PER_PHI/8-1.
REQ-017 SHALL pulse enable_cia for one clk at slot CLK_PER_PHI-1, unconditionally.
REQ-018 SHALL pulse enable_cpu for one clk at slot CLK_PER_PHI-1 only when stall is 0.
REQ-019 SHALL define stall = !ba && (!cpu_we || ba_cnt == 3), with cpu_we sampled at slot CLK_PER_PHI-2.
REQ-020 SHALL keep ba_cnt as a 2-bit saturating count of completed phi0 cycles with ba low; it increments at slot CLK_PER_PHI-1 while ba is low, saturates at 3, and clears to 0 in the cycle ba is sampled high.
REQ-021 SHALL drive aec = 0 when ba_cnt == 3 and ba is low, otherwise aec = 1.
REQ-022 SHALL drive vic_grant = !phi0 || !aec.
REQ-023 SHALL pulse pulse_rd for one clk at slot CLK_PER_PHI-4 when phi0 = 1, cpu_we = 0 and stall = 0; otherwise pulse_rd = 0.
REQ-024 SHALL perform a CPU write during ba-low cycles 0..2, then halt the CPU at the write once ba_cnt reaches 3.
REQ-025 SHALL resume the CPU when ba is high at slot CLK_PER_PHI-1; enable_cpu then fires in that same slot.
REQ-026 SHALL treat ba as changing only in phi0 = 0, and SHALL sample it once per cycle, at slot CLK_PER_PHI-2.
REQ-027 SHALL register every output; no combinational input-to-output path.

Reset
REQ-028 SHALL, while reset_n = 0, force slot = 0, ba_cnt = 0, phi0 = 0, aec = 1, vic_grant = 1, steal_cnt = 0, and all strobes = 0.
REQ-029 SHALL, on reset_n deassertion, emit the first enable_cpu exactly CLK_PER_PHI clks later (with ba high).
REQ-030 SHALL, on reset assertion mid-cycle, abort any pending strobe, with no pulse emitted in the following clk.

Configuration
REQ-031 SHALL, with macro MAX_BUS_SEQ_STEAL_CNT_EN defined, increment steal_cnt by 1 at each slot CLK_PER_PHI-1 where stall = 1, saturating at 16'hFFFF.
REQ-032 SHALL, with MAX_BUS_SEQ_STEAL_CNT_EN undefined, tie steal_cnt to 0 and instantiate no counter flops.

Structure
REQ-033 SHALL place the slot-offset constants (RD_SLOT_OFS = 4, SAMPLE_SLOT_OFS = 2) and the ba_cnt saturation value 3 in shared package max_pkg.
REQ-034 SHALL implement the ba_cnt/aec logic as sub-module max_ba_tracker, with ports clk, reset_n, tick, ba, ba_cnt, aec.

Verification
REQ-035 SHALL verify free-run, ba = 1, 1024 clks: enable_cpu/enable_cia = 32 pulses each, enable_pixel = 256 pulses, phi0 period = 32 clks with 50% duty.
REQ-036 SHALL verify ba falling during a CPU read: enable_cpu stops at the next slot 31; pulse_rd is absent; steal_cnt increments by 1 per cycle.
REQ-037 SHALL verify ba low with cpu_we = 1: three enable_cpu pulses, then aec = 0, vic_grant = 1 for the whole cycle, enable_cpu held.
REQ-038 SHALL verify ba rising after 40 stolen cycles: ba_cnt = 0, aec = 1, enable_cpu resumes in the same cycle; steal_cnt = 40 with macro defined, 0 without.
REQ-039 SHALL verify reset_n pulsed low at slot 17: all outputs return to reset values asynchronously; first enable_cpu appears 32 clks after release.
REQ-040 SHALL verify steal_cnt preloaded by forcing 65535 stalled cycles: it saturates at 16'hFFFF and does not wrap.
